// File: rtl/ew_result_collector.sv
// Element-wise result collector: packs the int8 output stream into
// buffer words, queues them in a small FIFO and signals completion.
module ew_result_collector #(
  parameter int INT8_WIDTH      = 8,
  parameter int MAX_VECTOR_SIZE = 8,
  parameter int ADDR_WIDTH      = 13,
  parameter int IDX_WIDTH       = 18,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [IDX_WIDTH-1:0]                  total_len,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  input  logic [INT8_WIDTH-1:0]                 data_in,
  input  logic                                  valid_in,
  input  logic [IDX_WIDTH-1:0]                  data_idx_in,
  output logic                                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                 mem_wr_addr,
  output logic [MAX_VECTOR_SIZE*INT8_WIDTH-1:0] mem_wr_data,
  output logic [MAX_VECTOR_SIZE-1:0]            mem_wr_strb,
  input  logic                                  mem_wr_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_overflow,
  output logic                                  err_order
);

  localparam int W  = MAX_VECTOR_SIZE * INT8_WIDTH;
  localparam int LW = $clog2(MAX_VECTOR_SIZE);
  localparam int FW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_COLLECT, S_FLUSH, S_DONE
  } state_t;

  state_t                  r_state;
  logic [IDX_WIDTH-1:0]    r_len;
  logic [IDX_WIDTH-1:0]    r_count;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_word_idx;
  logic [W-1:0]            r_lanes;
  logic                    r_err_ovf;
  logic                    r_err_ord;

  logic [W-1:0]               r_fdata [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]      r_faddr [FIFO_DEPTH];
  logic [MAX_VECTOR_SIZE-1:0] r_fstrb [FIFO_DEPTH];
  logic [FW-1:0]              r_wptr;
  logic [FW-1:0]              r_rptr;
  logic [FW:0]                r_fcnt;

  logic [LW-1:0]              w_lane;
  logic [W-1:0]               w_word;
  logic [MAX_VECTOR_SIZE-1:0] w_strb;
  logic                       w_accept;
  logic                       w_last;
  logic                       w_push;
  logic                       w_push_ok;
  logic                       w_pop;
  logic                       w_empty;
  logic                       w_full;

  assign w_lane   = r_count[LW-1:0];
  assign w_accept = (r_state == S_COLLECT) && valid_in;
  assign w_last   = (r_count + IDX_WIDTH'(1)) == r_len;
  assign w_push   = w_accept && ((&w_lane) || w_last);
  assign w_empty  = (r_fcnt == '0);
  assign w_full   = (r_fcnt == (FW+1)'(FIFO_DEPTH));
  assign w_pop    = !w_empty && mem_wr_ready;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_comb begin
    w_word = r_lanes;
    w_word[w_lane*INT8_WIDTH +: INT8_WIDTH] = data_in;
    for (int k = 0; k < MAX_VECTOR_SIZE; k++) begin
      w_strb[k] = (w_lane >= LW'(k));
    end
  end

  assign mem_wr_en    = !w_empty;
  assign mem_wr_addr  = w_empty ? '0 : r_faddr[r_rptr];
  assign mem_wr_data  = w_empty ? '0 : r_fdata[r_rptr];
  assign mem_wr_strb  = w_empty ? '0 : r_fstrb[r_rptr];
  assign busy         = (r_state == S_COLLECT) || (r_state == S_FLUSH);
  assign done         = (r_state == S_DONE);
  assign err_overflow = r_err_ovf;
  assign err_order    = r_err_ord;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_count    <= '0;
      r_base     <= '0;
      r_word_idx <= '0;
      r_lanes    <= '0;
      r_err_ovf  <= 1'b0;
      r_err_ord  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fcnt     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fdata[i] <= '0;
        r_faddr[i] <= '0;
        r_fstrb[i] <= '0;
      end
    end else begin
      if (w_pop) r_rptr <= r_rptr + FW'(1);
      if (w_push_ok) begin
        r_fdata[r_wptr] <= w_word;
        r_faddr[r_wptr] <= r_base + r_word_idx;
        r_fstrb[r_wptr] <= w_strb;
        r_wptr          <= r_wptr + FW'(1);
      end
      if (w_push_ok && !w_pop)      r_fcnt <= r_fcnt + (FW+1)'(1);
      else if (!w_push_ok && w_pop) r_fcnt <= r_fcnt - (FW+1)'(1);
      if (w_push && !w_push_ok) r_err_ovf <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len      <= total_len;
            r_base     <= base_addr;
            r_count    <= '0;
            r_word_idx <= '0;
            r_lanes    <= '0;
            r_err_ovf  <= 1'b0;
            r_err_ord  <= 1'b0;
            r_state    <= (total_len == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (valid_in) begin
            r_count <= r_count + IDX_WIDTH'(1);
            if (data_idx_in != r_count) r_err_ord <= 1'b1;
            if (w_push) begin
              r_lanes    <= '0;
              r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
            end else begin
              r_lanes <= w_word;
            end
            if (w_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_empty) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ew_result_collector.sv
// Directed bench for ew_result_collector: packing, wrap, overflow,
// ordering error, reset mid-run and zero-length start.
module tb_ew_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] total_len;
  logic [12:0] base_addr;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [17:0] data_idx_in;
  logic        mem_wr_en;
  logic [12:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_strb;
  logic        mem_wr_ready;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic        err_order;

  int total = 0;
  int bad   = 0;

  logic [12:0] wa[$];
  logic [63:0] wd[$];
  logic [7:0]  ws[$];
  int          done_cnt = 0;

  ew_result_collector dut (
    .clk(clk), .rst(rst), .start(start),
    .total_len(total_len), .base_addr(base_addr),
    .data_in(data_in), .valid_in(valid_in),
    .data_idx_in(data_idx_in),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .mem_wr_ready(mem_wr_ready),
    .busy(busy), .done(done),
    .err_overflow(err_overflow), .err_order(err_order)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en && mem_wr_ready) begin
      wa.push_back(mem_wr_addr);
      wd.push_back(mem_wr_data);
      ws.push_back(mem_wr_strb);
    end
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input logic [12:0] base);
    wa.delete(); wd.delete(); ws.delete();
    start = 1'b1;
    total_len = 18'(len);
    base_addr = base;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    valid_in = 1'b1;
    data_idx_in = 18'(idx);
    data_in = d;
    cyc();
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] qd(input int k);
    return (wd.size() > k) ? wd[k] : 64'hx;
  endfunction

  function automatic logic [12:0] qa(input int k);
    return (wa.size() > k) ? wa[k] : 13'hx;
  endfunction

  function automatic logic [7:0] qs(input int k);
    return (ws.size() > k) ? ws[k] : 8'hx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    total++;
    if ({mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb} !== '0) begin
      bad++;
      $display("FAIL reset_mem: got en=%b a=%h d=%h s=%h want 0",
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb);
    end
    total++;
    if ({busy, done, err_overflow, err_order} !== 4'b0) begin
      bad++;
      $display("FAIL reset_status: got %b want 0000",
               {busy, done, err_overflow, err_order});
    end
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    mem_wr_ready = 1'b1;
    do_start(8, 13'h010);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL basic_busy: got %b want 1", busy);
    end
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) send(i, 8'(i + 1));
    total++;
    if ({mem_wr_en, mem_wr_addr} !== {1'b1, 13'h010}) begin
      bad++;
      $display("FAIL basic_latency: got en=%b a=%h want en=1 a=010",
               mem_wr_en, mem_wr_addr);
    end
    wait_done(50, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL basic_timeout: got no done want done");
    end
    cyc();
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL basic_pulse: got done,busy=%b want 00", {done, busy});
    end
    total++;
    if (wa.size() != 1 || qa(0) !== 13'h010 || qs(0) !== 8'hFF ||
        qd(0) !== 64'h0807060504030201) begin
      bad++;
      $display("FAIL basic_write: got n=%0d a=%h d=%h s=%h want 1 010 0807060504030201 ff",
               wa.size(), qa(0), qd(0), qs(0));
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int d0;
    mem_wr_ready = 1'b1;
    do_start(11, 13'h1FFF);
    d0 = done_cnt;
    for (int i = 0; i < 11; i++) send(i, 8'(8'hA0 + i));
    wait_done(50, ok);
    cyc();
    total++;
    if (!ok || done_cnt - d0 != 1) begin
      bad++; $display("FAIL wrap_done: got ok=%b n=%0d want 1 1", ok, done_cnt - d0);
    end
    total++;
    if (wa.size() != 2) begin
      bad++; $display("FAIL wrap_count: got %0d want 2", wa.size());
    end
    total++;
    if (qa(0) !== 13'h1FFF || qs(0) !== 8'hFF || qd(0) !== 64'hA7A6A5A4A3A2A1A0) begin
      bad++;
      $display("FAIL wrap_w0: got a=%h d=%h s=%h want 1fff a7a6a5a4a3a2a1a0 ff",
               qa(0), qd(0), qs(0));
    end
    total++;
    if (qa(1) !== 13'h0000 || qs(1) !== 8'h07 || qd(1) !== 64'h0000000000AAA9A8) begin
      bad++;
      $display("FAIL wrap_w1: got a=%h d=%h s=%h want 0000 0000000000aaa9a8 07",
               qa(1), qd(1), qs(1));
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int d0;
    mem_wr_ready = 1'b0;
    do_start(40, 13'h100);
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      valid_in = 1'b1;
      data_idx_in = 18'(i);
      data_in = 8'(i + 1);
      cyc();
    end
    valid_in = 1'b0;
    repeat (5) cyc();
    total++;
    if (err_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_flag: got %b want 1", err_overflow);
    end
    total++;
    if ({mem_wr_en, mem_wr_addr, mem_wr_strb} !== {1'b1, 13'h100, 8'hFF} ||
        mem_wr_data !== 64'h0807060504030201 || wa.size() != 0) begin
      bad++;
      $display("FAIL ovf_hold: got en=%b a=%h d=%h n=%0d want 1 100 0807060504030201 0",
               mem_wr_en, mem_wr_addr, mem_wr_data, wa.size());
    end
    mem_wr_ready = 1'b1;
    wait_done(50, ok);
    cyc();
    total++;
    if (!ok || done_cnt - d0 != 1) begin
      bad++; $display("FAIL ovf_done: got ok=%b n=%0d want 1 1", ok, done_cnt - d0);
    end
    total++;
    if (wa.size() != 4 || qa(3) !== 13'h103 || qd(3) !== 64'h201F1E1D1C1B1A19) begin
      bad++;
      $display("FAIL ovf_writes: got n=%0d a3=%h d3=%h want 4 103 201f1e1d1c1b1a19",
               wa.size(), qa(3), qd(3));
    end
    total++;
    if (err_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got %b want 1", err_overflow);
    end
  endtask

  task automatic test_order();
    bit ok;
    int d0;
    mem_wr_ready = 1'b1;
    do_start(16, 13'h020);
    total++;
    if (err_overflow !== 1'b0) begin
      bad++; $display("FAIL order_clear: got ovf=%b want 0", err_overflow);
    end
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) send((i == 3) ? 9 : i, 8'(8'h10 + i));
    wait_done(50, ok);
    cyc();
    total++;
    if (err_order !== 1'b1) begin
      bad++; $display("FAIL order_flag: got %b want 1", err_order);
    end
    total++;
    if (!ok || done_cnt - d0 != 1) begin
      bad++; $display("FAIL order_done: got ok=%b n=%0d want 1 1", ok, done_cnt - d0);
    end
    total++;
    if (wa.size() != 2 || qd(0) !== 64'h1716151413121110 ||
        qd(1) !== 64'h1F1E1D1C1B1A1918 || qa(1) !== 13'h021) begin
      bad++;
      $display("FAIL order_data: got n=%0d d0=%h d1=%h a1=%h want 2 1716151413121110 1f1e1d1c1b1a1918 021",
               wa.size(), qd(0), qd(1), qa(1));
    end
  endtask

  task automatic test_rst_mid();
    int d0;
    mem_wr_ready = 1'b1;
    do_start(16, 13'h040);
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) send(i, 8'(8'h30 + i));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if ({mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb,
         busy, done, err_overflow, err_order} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got en=%b busy=%b done=%b want all 0",
               mem_wr_en, busy, done);
    end
    repeat (5) cyc();
    total++;
    if (wa.size() != 0 || done_cnt != d0) begin
      bad++;
      $display("FAIL rst_mid_quiet: got writes=%0d dones=%0d want 0 0",
               wa.size(), done_cnt - d0);
    end
    do_start(0, 13'h055);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL zero_len_done: got %b want 1", done);
    end
    cyc();
    total++;
    if (done !== 1'b0 || wa.size() != 0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL zero_len_pulse: got done=%b writes=%0d n=%0d want 0 0 1",
               done, wa.size(), done_cnt - d0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    total_len = '0;
    base_addr = '0;
    data_in = '0;
    valid_in = 1'b0;
    data_idx_in = '0;
    mem_wr_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_order();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
